word_serializer: RTL and testbench

//  Upstream feeder for the bit-serial parity stage. Accepts a parallel word over a

---
 rtl/word_serializer.sv | 153 +++++++++++++++
 tb/tb_word_serializer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// Word serializer: accepts a parallel word over a valid/ready handshake and shifts it
// out one bit per clock with first/last frame markers, followed by a programmable idle
// gap. ser_first doubles as the per-frame clear of the downstream parity stage.
module word_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned GAP       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_din_valid,
  output logic             o_din_ready,
  output logic             o_ser_out,
  output logic             o_ser_valid,
  output logic             o_ser_first,
  output logic             o_ser_last,
  output logic             o_busy
);

  localparam int unsigned   CW          = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LP_CNT_PEN  = CW'(WIDTH - 2);
  localparam logic [3:0]    LP_GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);
  localparam bit            LP_NO_GAP   = (GAP == 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_gap;
  logic [WIDTH-1:0] r_shift;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_ser_first;
  logic             r_ser_last;
  logic             r_busy;

  logic [1:0]       w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [3:0]       w_gap_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_out_nxt;
  logic             w_valid_nxt;
  logic             w_first_nxt;
  logic             w_last_nxt;
  logic             w_last;
  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_rotated;

  // The shift register is rotated rather than shifted so every bit stays in use; the
  // next bit to present always sits one position in from the output end.
  always_comb begin
    w_last      = (r_state == ST_SHIFT) && (r_cnt == LP_CNT_LAST);
    o_din_ready = (r_state == ST_IDLE) || (w_last && LP_NO_GAP);
    w_accept    = i_din_valid && o_din_ready;
    w_first_bit = MSB_FIRST ? i_din[WIDTH-1] : i_din[0];
    w_next_bit  = MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];
    w_rotated   = MSB_FIRST ? {r_shift[WIDTH-2:0], r_shift[WIDTH-1]}
                            : {r_shift[0], r_shift[WIDTH-1:1]};
  end

  // Next-state logic for the FSM, counters and the registered serial outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_shift_nxt = r_shift;
    w_out_nxt   = 1'b0;
    w_valid_nxt = 1'b0;
    w_first_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
          w_shift_nxt = i_din;
          w_out_nxt   = w_first_bit;
          w_valid_nxt = 1'b1;
          w_first_nxt = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!w_last) begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_shift_nxt = w_rotated;
          w_out_nxt   = w_next_bit;
          w_valid_nxt = 1'b1;
          w_last_nxt  = (r_cnt == LP_CNT_PEN);
        end else if (!LP_NO_GAP) begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = '0;
        end else if (w_accept) begin
          // Gapless back-to-back: the new word's first bit follows ser_last directly.
          w_cnt_nxt   = '0;
          w_shift_nxt = i_din;
          w_out_nxt   = w_first_bit;
          w_valid_nxt = 1'b1;
          w_first_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gap == LP_GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight and drops the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_shift     <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_first <= 1'b0;
      r_ser_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gap       <= w_gap_nxt;
      r_shift     <= w_shift_nxt;
      r_ser_out   <= w_out_nxt;
      r_ser_valid <= w_valid_nxt;
      r_ser_first <= w_first_nxt;
      r_ser_last  <= w_last_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_ser_out   = r_ser_out;
  assign o_ser_valid = r_ser_valid;
  assign o_ser_first = r_ser_first;
  assign o_ser_last  = r_ser_last;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: four instances cover LSB-first, MSB-first,
// GAP=2 and GAP=0; a bench-side parity accumulator stands in for the parity stage.
module tb_word_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din [4];
  logic [3:0] vld;
  logic [3:0] rdy;
  logic [3:0] sout;
  logic [3:0] sval;
  logic [3:0] sfst;
  logic [3:0] slst;
  logic [3:0] bsy;
  int         n_assert = 0;
  int         n_fail = 0;
  bit         par;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(1)) u_lsb (
    .clk(clk), .reset(reset), .i_din(din[0]), .i_din_valid(vld[0]), .o_din_ready(rdy[0]),
    .o_ser_out(sout[0]), .o_ser_valid(sval[0]), .o_ser_first(sfst[0]),
    .o_ser_last(slst[0]), .o_busy(bsy[0])
  );
  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(1)) u_msb (
    .clk(clk), .reset(reset), .i_din(din[1]), .i_din_valid(vld[1]), .o_din_ready(rdy[1]),
    .o_ser_out(sout[1]), .o_ser_valid(sval[1]), .o_ser_first(sfst[1]),
    .o_ser_last(slst[1]), .o_busy(bsy[1])
  );
  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(2)) u_gap2 (
    .clk(clk), .reset(reset), .i_din(din[2]), .i_din_valid(vld[2]), .o_din_ready(rdy[2]),
    .o_ser_out(sout[2]), .o_ser_valid(sval[2]), .o_ser_first(sfst[2]),
    .o_ser_last(slst[2]), .o_busy(bsy[2])
  );
  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0)) u_gap0 (
    .clk(clk), .reset(reset), .i_din(din[3]), .i_din_valid(vld[3]), .o_din_ready(rdy[3]),
    .o_ser_out(sout[3]), .o_ser_valid(sval[3]), .o_ser_first(sfst[3]),
    .o_ser_last(slst[3]), .o_busy(bsy[3])
  );

  // One cycle forward; sampling and driving both happen on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed status {ser_out, ser_valid, ser_first, ser_last, busy, din_ready}.
  function automatic logic [5:0] st(input int d);
    return {sout[d], sval[d], sfst[d], slst[d], bsy[d], rdy[d]};
  endfunction

  // Checks WIDTH frame cycles; parity is accumulated from the observed stream,
  // cleared on ser_first as the downstream stage would.
  task automatic word(input int d, input int b[8], input bit rdy_last, input string tag,
                      output bit p);
    logic [5:0] e;
    p = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e = {b[k] != 0, 1'b1, k == 0, k == 7, 1'b1, (k == 7) && rdy_last};
      chk($sformatf("%s bit%0d", tag, k), st(d), e);
      if (sfst[d]) p = 1'b0;
      if (sval[d]) p = p ^ sout[d];
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    vld   = '0;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    tick();
    tick();
    for (int d = 0; d < 4; d++) chk($sformatf("reset dut%0d", d), st(d), 6'b000001);
    reset = 1'b0;
    tick();

    // LSB first, 8'h1D
    din[0] = 8'h1D;
    vld[0] = 1'b1;
    chk("t1 ready", rdy[0], 1);
    tick();
    vld[0] = 1'b0;
    din[0] = 8'hE2;  // changes while busy must be ignored
    word(0, '{1, 0, 1, 1, 1, 0, 0, 0}, 1'b0, "t1", par);
    chk("t1 parity", par, 0);
    chk("t1 gap", st(0), 6'b000010);
    tick();
    chk("t1 idle", st(0), 6'b000001);

    // MSB first, 8'h1D
    din[1] = 8'h1D;
    vld[1] = 1'b1;
    tick();
    vld[1] = 1'b0;
    word(1, '{0, 0, 0, 1, 1, 1, 0, 1}, 1'b0, "t2", par);
    chk("t2 gap", st(1), 6'b000010);
    tick();
    chk("t2 idle", st(1), 6'b000001);

    // GAP=2 with din_valid held high across both words
    din[2] = 8'h1D;
    vld[2] = 1'b1;
    tick();
    din[2] = 8'h80;
    word(2, '{1, 0, 1, 1, 1, 0, 0, 0}, 1'b0, "t3a", par);
    chk("t3 gap c9", st(2), 6'b000010);
    tick();
    chk("t3 gap c10", st(2), 6'b000010);
    tick();
    chk("t3 idle c11", st(2), 6'b000001);
    tick();
    vld[2] = 1'b0;
    word(2, '{0, 0, 0, 0, 0, 0, 0, 1}, 1'b0, "t3b", par);
    chk("t3 parity 80", par, 1);
    tick();
    tick();
    chk("t3 idle end", st(2), 6'b000001);

    // GAP=0 back-to-back: 1D then 07 with no idle cycle between frames
    din[3] = 8'h1D;
    vld[3] = 1'b1;
    chk("t4 ready idle", rdy[3], 1);
    tick();
    din[3] = 8'h07;
    word(3, '{1, 0, 1, 1, 1, 0, 0, 0}, 1'b1, "t4a", par);
    vld[3] = 1'b0;
    chk("t4 parity 1D", par, 0);
    word(3, '{1, 1, 1, 0, 0, 0, 0, 0}, 1'b1, "t4b", par);
    chk("t4 parity 07", par, 1);
    chk("t4 idle", st(3), 6'b000001);

    // Reset in the middle of a frame, then reset together with din_valid
    din[0] = 8'h1D;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    chk("t5 c1", st(0), 6'b111010);
    tick();
    chk("t5 c2", st(0), 6'b010010);
    tick();
    chk("t5 c3", st(0), 6'b110010);
    tick();
    chk("t5 c4", st(0), 6'b110010);
    reset = 1'b1;
    tick();
    chk("t5 after reset", st(0), 6'b000001);
    din[0] = 8'h07;
    vld[0] = 1'b1;
    tick();
    chk("t5 reset wins", st(0), 6'b000001);
    reset = 1'b0;
    tick();
    vld[0] = 1'b0;
    word(0, '{1, 1, 1, 0, 0, 0, 0, 0}, 1'b0, "t5", par);
    chk("t5 parity", par, 1);
    chk("t5 gap", st(0), 6'b000010);
    tick();
    chk("t5 idle", st(0), 6'b000001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
